// File: rtl/i2c_target_if.sv
// i2c_target_if: bus-side and register-side signals of the I2C target.
//   slave  modport : the target itself (samples SCL/SDA and read data,
//                    drives SDA release/pull, register strobes and status).
//   master modport : the environment (bus controller and register space).
// Ports carried:
//   scl_in, sda_in      bus clock / data as seen on the wire (asynchronous)
//   sda_out             0 = pull SDA low, 1 = release
//   reg_addr            current register pointer (PTR_W bits)
//   reg_wdata, reg_we   write data and one-cycle write strobe
//   reg_rd, reg_rdata   one-cycle read strobe, data sampled on the next MCLK
//   busy, status        transaction activity and decoded phase
interface i2c_target_if #(
  parameter int unsigned PTR_W = 8
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_out;
  logic [PTR_W-1:0] reg_addr;
  logic [7:0]       reg_wdata;
  logic             reg_we;
  logic             reg_rd;
  logic [7:0]       reg_rdata;
  logic             busy;
  logic [2:0]       status;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_out, reg_addr, reg_wdata, reg_we, reg_rd, busy, status
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_out, reg_addr, reg_wdata, reg_we, reg_rd, busy, status
  );
endinterface

// File: rtl/i2c_target.sv
// i2c_target: I2C responder in front of an external byte-addressed register
// space. Oversamples SCL/SDA on mclk, decodes START/STOP, the 7-bit address,
// a register pointer, write bytes and auto-incrementing read bytes, and
// drives SDA open-drain style.
// Ports:
//   mclk  system clock
//   srst  synchronous active-high reset
//   bus   i2c_target_if.slave (SCL/SDA, register strobe interface, status)
// Parameters:
//   ADDR   7-bit target address answered
//   PTR_W  register pointer width; the pointer wraps modulo 2^PTR_W
// Optional build macro:
//   I2CTGT_GLITCH_FILTER_EN  adds a 3-sample majority filter after the
//   synchronisers (2 extra cycles of latency, 1-cycle pulses rejected;
//   SCL phases must then be at least 6 mclk long instead of 4).
module i2c_target #(
  parameter logic [6:0]  ADDR  = 7'h68,
  parameter int unsigned PTR_W = 8
) (
  input logic         mclk,
  input logic         srst,
  i2c_target_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);

  typedef enum logic [2:0] {
    T_IDLE,
    T_ADDR,
    T_PTR,
    T_WDATA,
    T_RDATA,
    T_IGNORE
  } state_t;

  // Input synchronisers
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;

  always_ff @(posedge mclk) begin
    if (srst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
    end
  end

  logic scl_cur;
  logic sda_cur;

`ifdef I2CTGT_GLITCH_FILTER_EN
  // Majority of the newest synchronised sample and the two before it,
  // registered: a single-cycle pulse never wins the vote.
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;
  logic       scl_flt;
  logic       sda_flt;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge mclk) begin
    if (srst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_flt  <= 1'b1;
      sda_flt  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_flt  <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
      sda_flt  <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
    end
  end

  assign scl_cur = scl_flt;
  assign sda_cur = sda_flt;
`else
  assign scl_cur = scl_sync[1];
  assign sda_cur = sda_sync[1];
`endif

  // Previous conditioned sample, used for edge detection
  logic scl_prev;
  logic sda_prev;

  always_ff @(posedge mclk) begin
    if (srst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_cur;
      sda_prev <= sda_cur;
    end
  end

  logic start_det;
  logic stop_det;
  logic scl_rise;
  logic scl_fall;

  assign start_det = scl_cur & scl_prev & sda_prev & ~sda_cur;
  assign stop_det  = scl_cur & scl_prev & ~sda_prev & sda_cur;
  assign scl_rise  = scl_cur & ~scl_prev;
  assign scl_fall  = ~scl_cur & scl_prev;

  // Protocol state
  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       txreg;
  logic             in_slot;
  logic             rnw;
  logic             rd_req;
  logic             sda_q;
  logic             busy_q;
  logic             we_q;
  logic             rd_q;
  logic [7:0]       wdata_q;
  logic [PTR_W-1:0] ptr;

  // Main protocol engine. START/STOP take priority over SCL edges.
  // bit_cnt counts SCL rises within the current byte; in_slot marks the
  // target-driven ACK slot of a byte the target received.
  always_ff @(posedge mclk) begin
    if (srst) begin
      state   <= T_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      txreg   <= '1;
      in_slot <= 1'b0;
      rnw     <= 1'b0;
      rd_req  <= 1'b0;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      ptr     <= '0;
    end else begin
      we_q   <= 1'b0;
      rd_q   <= 1'b0;
      rd_req <= 1'b0;

      // Post-write increment lands the cycle after the strobe
      if (we_q) begin
        ptr <= ptr + PTR_W'(1);
      end
      // Read data is captured the cycle after the read strobe
      if (rd_q) begin
        txreg <= bus.reg_rdata;
      end
      if (rd_req) begin
        rd_q <= 1'b1;
      end

      if (start_det) begin
        state   <= T_ADDR;
        bit_cnt <= '0;
        in_slot <= 1'b0;
        sda_q   <= 1'b1;
      end else if (stop_det) begin
        state   <= T_IDLE;
        bit_cnt <= '0;
        in_slot <= 1'b0;
        sda_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          T_ADDR, T_PTR, T_WDATA: begin
            if (scl_rise && !in_slot && bit_cnt != BYTE_BITS) begin
              shreg   <= {shreg[6:0], sda_cur};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (scl_fall && in_slot) begin
              // Slot-closing fall: release ACK, move to the next phase
              in_slot <= 1'b0;
              sda_q   <= 1'b1;
              if (state == T_ADDR) begin
                if (rnw) begin
                  state <= T_RDATA;
                  sda_q <= txreg[7];
                  txreg <= {txreg[6:0], 1'b1};
                end else begin
                  state <= T_PTR;
                end
              end else if (state == T_PTR) begin
                state <= T_WDATA;
              end
            end else if (scl_fall && bit_cnt == BYTE_BITS) begin
              // Slot-opening fall after a full byte
              bit_cnt <= '0;
              case (state)
                T_ADDR: begin
                  if (shreg[7:1] == ADDR) begin
                    in_slot <= 1'b1;
                    sda_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    rnw     <= shreg[0];
                    rd_q    <= shreg[0];
                  end else begin
                    state <= T_IGNORE;
                  end
                end
                T_PTR: begin
                  ptr     <= PTR_W'(shreg);
                  in_slot <= 1'b1;
                  sda_q   <= 1'b0;
                end
                default: begin
                  we_q    <= 1'b1;
                  wdata_q <= shreg;
                  in_slot <= 1'b1;
                  sda_q   <= 1'b0;
                end
              endcase
            end
          end

          T_RDATA: begin
            if (scl_fall) begin
              // bit_cnt==8: bit0 was sampled, hand SDA to the controller
              if (bit_cnt == BYTE_BITS) begin
                sda_q <= 1'b1;
              end else begin
                sda_q <= txreg[7];
                txreg <= {txreg[6:0], 1'b1};
              end
            end else if (scl_rise) begin
              if (bit_cnt == BYTE_BITS) begin
                // 9th rise: controller ACK continues the burst
                bit_cnt <= '0;
                if (!sda_cur) begin
                  ptr    <= ptr + PTR_W'(1);
                  rd_req <= 1'b1;
                end else begin
                  state <= T_IGNORE;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          default: begin
            sda_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Status decode, registered
  logic [2:0] status_q;

  always_ff @(posedge mclk) begin
    if (srst) begin
      status_q <= 3'd0;
    end else if (in_slot || (state == T_RDATA && bit_cnt == BYTE_BITS)) begin
      status_q <= 3'd5;
    end else begin
      case (state)
        T_ADDR:   status_q <= 3'd1;
        T_PTR:    status_q <= 3'd2;
        T_WDATA:  status_q <= 3'd3;
        T_RDATA:  status_q <= 3'd4;
        T_IGNORE: status_q <= 3'd7;
        default:  status_q <= 3'd0;
      endcase
    end
  end

  // SDA is released as soon as reset is asserted, not one edge later
  assign bus.sda_out   = sda_q | srst;
  assign bus.reg_addr  = ptr;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_rd    = rd_q;
  assign bus.busy      = busy_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target. Acts as I2C controller and
// register space; the SDA wire is the AND of controller drive and target
// drive. Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int unsigned HALF = 8;

  logic mclk = 1'b0;
  logic srst;
  logic scl_drv;
  logic sda_drv;
  logic sda_line;

  always #5 mclk = ~mclk;

  i2c_target_if #(.PTR_W(8)) bus ();

  i2c_target #(.ADDR(7'h68), .PTR_W(8)) dut (
    .mclk (mclk),
    .srst (srst),
    .bus  (bus)
  );

  logic [7:0] mem [256];

  assign sda_line      = sda_drv & bus.sda_out;
  assign bus.scl_in    = scl_drv;
  assign bus.sda_in    = sda_line;
  assign bus.reg_rdata = mem[bus.reg_addr];

  logic [15:0] we_log [$];
  logic [7:0]  rd_log [$];
  int          low_cnt;

  always @(negedge mclk) begin
    if (bus.reg_we) we_log.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_rd) rd_log.push_back(bus.reg_addr);
    if (!bus.sda_out) low_cnt++;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // One SCL clock; optional 1-cycle low glitch in the middle of the high phase
  task automatic send_bit(input logic b, input bit glitch, output logic s);
    sda_drv = b;
    wait_cyc(HALF);
    scl_drv = 1'b1;
    wait_cyc(HALF / 2);
    s = sda_line;
    if (glitch) begin
      scl_drv = 1'b0;
      wait_cyc(1);
      scl_drv = 1'b1;
    end
    wait_cyc(HALF / 2);
    scl_drv = 1'b0;
    wait_cyc(2);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_cyc(HALF);
    scl_drv = 1'b1;
    wait_cyc(HALF);
    sda_drv = 1'b0;
    wait_cyc(HALF);
    scl_drv = 1'b0;
    wait_cyc(2);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_cyc(HALF);
    scl_drv = 1'b1;
    wait_cyc(HALF);
    sda_drv = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch && (i == 4), s);
    send_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    send_bit(~give_ack, 1'b0, s);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic [7:0] d;
    logic [7:0] exp_ptr;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h75] = 8'h68;
    mem[8'h76] = 8'h71;
    low_cnt = 0;
    srst    = 1'b1;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    wait_cyc(5);
    srst = 1'b0;
    wait_cyc(3);

    // Reset state
    check("rst sda_out", bus.sda_out, 1);
    check("rst reg_addr", bus.reg_addr, 0);
    check("rst busy", bus.busy, 0);
    check("rst status", bus.status, 0);
    check("rst strobes", {bus.reg_we, bus.reg_rd}, 0);

    // 1. Write burst
    we_log.delete();
    i2c_start();
    write_byte(8'hD0, 0, a); check("t1 ack addr", a, 1);
    write_byte(8'h3B, 0, a); check("t1 ack ptr", a, 1);
    wait_cyc(6);
    check("t1 status wdata", bus.status, 3);
    write_byte(8'hA5, 0, a); check("t1 ack d0", a, 1);
    write_byte(8'h5A, 0, a); check("t1 ack d1", a, 1);
    check("t1 busy", bus.busy, 1);
    i2c_stop();
    check("t1 busy stop", bus.busy, 0);
    check("t1 status idle", bus.status, 0);
    check("t1 we count", we_log.size(), 2);
    if (we_log.size() == 2) begin
      check("t1 we0", we_log[0], 16'h3BA5);
      check("t1 we1", we_log[1], 16'h3C5A);
    end
    check("t1 reg_addr", bus.reg_addr, 8'h3D);

    // 2. Pointer set, repeated START, two-byte read
    rd_log.delete();
    we_log.delete();
    i2c_start();
    write_byte(8'hD0, 0, a); check("t2 ack addr", a, 1);
    write_byte(8'h75, 0, a); check("t2 ack ptr", a, 1);
    i2c_start();
    write_byte(8'hD1, 0, a); check("t2 ack raddr", a, 1);
    read_byte(1'b1, d); check("t2 rd0", d, 8'h68);
    read_byte(1'b0, d); check("t2 rd1", d, 8'h71);
    wait_cyc(4);
    check("t2 sda released", bus.sda_out, 1);
    check("t2 status ignore", bus.status, 7);
    check("t2 rd count", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      check("t2 rd addr0", rd_log[0], 8'h75);
      check("t2 rd addr1", rd_log[1], 8'h76);
    end
    check("t2 no we", we_log.size(), 0);
    i2c_stop();
    check("t2 busy stop", bus.busy, 0);
    check("t2 reg_addr", bus.reg_addr, 8'h76);

    // 3. Address mismatch
    rd_log.delete();
    we_log.delete();
    low_cnt = 0;
    i2c_start();
    write_byte(8'hA0, 0, a); check("t3 nack addr", a, 0);
    write_byte(8'h00, 0, a); check("t3 nack data", a, 0);
    check("t3 status ignore", bus.status, 7);
    check("t3 busy", bus.busy, 0);
    check("t3 sda low cycles", low_cnt, 0);
    check("t3 no strobes", we_log.size() + rd_log.size(), 0);
    i2c_stop();
    check("t3 status idle", bus.status, 0);

    // 4. Reset in the middle of a read byte (0x71 from pointer 76)
    i2c_start();
    write_byte(8'hD1, 0, a); check("t4 ack addr", a, 1);
    for (int i = 7; i >= 4; i--) begin
      send_bit(1'b1, 1'b0, a);
      d[i] = a;
    end
    check("t4 rd nibble", d[7:4], 4'h7);
    wait_cyc(4);
    check("t4 drive bit3", bus.sda_out, 0);
    srst = 1'b1;
    wait_cyc(1);
    check("t4 srst sda_out", bus.sda_out, 1);
    check("t4 srst status", bus.status, 0);
    check("t4 srst reg_addr", bus.reg_addr, 0);
    check("t4 srst busy", bus.busy, 0);
    srst = 1'b0;
    wait_cyc(4);
    i2c_start();
    write_byte(8'hD0, 0, a); check("t4 ack after rst", a, 1);
    write_byte(8'h20, 0, a); check("t4 ack ptr", a, 1);
    i2c_stop();
    check("t4 reg_addr", bus.reg_addr, 8'h20);

    // 5. Pointer wrap
    we_log.delete();
    i2c_start();
    write_byte(8'hD0, 0, a); check("t5 ack addr", a, 1);
    write_byte(8'hFF, 0, a); check("t5 ack ptr", a, 1);
    write_byte(8'h11, 0, a); check("t5 ack d0", a, 1);
    write_byte(8'h22, 0, a); check("t5 ack d1", a, 1);
    i2c_stop();
    check("t5 we count", we_log.size(), 2);
    if (we_log.size() == 2) begin
      check("t5 we0", we_log[0], 16'hFF11);
      check("t5 we1", we_log[1], 16'h0022);
    end
    check("t5 reg_addr", bus.reg_addr, 8'h01);

    // 6. 1-cycle SCL low glitch during the pointer byte 0x5A
    we_log.delete();
    i2c_start();
    write_byte(8'hD0, 0, a); check("t6 ack addr", a, 1);
    write_byte(8'h5A, 1, a);
`ifdef I2CTGT_GLITCH_FILTER_EN
    check("t6 ack ptr", a, 1);
    exp_ptr = 8'h5A;
`else
    exp_ptr = 8'h5D;
`endif
    i2c_stop();
    check("t6 reg_addr", bus.reg_addr, exp_ptr);
    check("t6 status idle", bus.status, 0);
    check("t6 no we", we_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
